// File: rtl/bpu_dyn_bp_pkg.sv
// Shared configuration for the dynamic branch predictor:
// default widths and the link-register convention.
package bpu_dyn_bp_pkg;

  localparam int XLEN_D  = 32;
  localparam int CNT_W_D = 2;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack: circular buffer that wraps
// when full, overwriting the oldest entry.
module bpu_ras
  import bpu_dyn_bp_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int SP_W = $clog2(DEPTH);
  localparam logic [SP_W:0] CNT_MAX = (SP_W+1)'(DEPTH);

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic [SP_W:0]   cnt;
  logic [XLEN-1:0] mem [DEPTH];

  logic wr_new;
  logic wr_top;
  logic do_pop;

  assign sp_m1  = sp - SP_W'(1);
  assign empty  = (cnt == '0);
  assign top    = mem[sp_m1];

  // push+pop on a non-empty stack replaces the top in place
  assign wr_new = push & (~pop | empty);
  assign wr_top = push & pop & ~empty;
  assign do_pop = pop & ~push & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sp  <= '0;
      cnt <= '0;
    end else if (wr_new) begin
      sp  <= sp + SP_W'(1);
      cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else if (do_pop) begin
      sp  <= sp_m1;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr_new) begin
        mem[sp] <= wdata;
      end else if (wr_top) begin
        mem[sp_m1] <= wdata;
      end
    end
  end

endmodule

// File: rtl/bpu_dyn_bp.sv
// Dynamic branch predictor: BHT of saturating counters
// for bxx, RAS for jalr returns, combinational predict.
module bpu_dyn_bp
  import bpu_dyn_bp_pkg::*;
#(
  parameter int XLEN      = XLEN_D,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = CNT_W_D,
  parameter int RAS_DEPTH = 4,
  parameter int MODE      = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_dec_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_inst_jal,
  input  logic            i_inst_jalr,
  input  logic            i_inst_bxx,
  input  logic            i_inst_rs1ren,
  input  logic [4:0]      i_rs1_idx,
  input  logic [4:0]      i_rd_idx,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_jalr_rs1rdata,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic            i_ras_flush,
  output logic            o_prdt_taken,
  output logic [XLEN-1:0] o_prdt_pc,
  output logic            o_ras_hit
);

  localparam int BHT_N = 2 ** BHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_RST =
    {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     bht [BHT_N];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] up_idx;
  logic                 unused_upd;

  logic            push;
  logic            pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic [XLEN-1:0] tgt;

  assign rd_idx = i_pc[BHT_IDX_W+1:2];
  assign up_idx = i_upd_pc[BHT_IDX_W+1:2];
  assign unused_upd =
    ^{i_upd_pc[XLEN-1:BHT_IDX_W+2], i_upd_pc[1:0]};

  assign push = (i_inst_jal | i_inst_jalr) & is_link(i_rd_idx);
  // rd==rs1 both link: a call through ra, not a return
  assign pop  = i_inst_jalr & is_link(i_rs1_idx)
              & ~(is_link(i_rd_idx) & (i_rd_idx == i_rs1_idx));

  bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push & i_dec_valid),
    .pop   (pop & i_dec_valid),
    .flush (i_ras_flush),
    .wdata (i_pc + XLEN'(4)),
    .top   (ras_top),
    .empty (ras_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= CNT_RST;
      end
    end else if ((MODE != 0) && i_upd_valid) begin
      if (i_upd_taken && bht[up_idx] != CNT_MAX) begin
        bht[up_idx] <= bht[up_idx] + 1'b1;
      end else if (!i_upd_taken && bht[up_idx] != '0) begin
        bht[up_idx] <= bht[up_idx] - 1'b1;
      end
    end
  end

  assign tgt = i_pc + i_imm;

  always_comb begin
    o_prdt_taken = 1'b0;
    o_prdt_pc    = tgt;
    o_ras_hit    = 1'b0;
    unique case (1'b1)
      i_inst_jal: begin
        o_prdt_taken = 1'b1;
      end
      i_inst_jalr: begin
        o_prdt_taken = 1'b1;
        if (pop && !ras_empty) begin
          o_prdt_pc = ras_top;
          o_ras_hit = 1'b1;
        end else if (i_inst_rs1ren) begin
          o_prdt_pc = i_jalr_rs1rdata + i_imm;
        end else begin
          o_prdt_pc = i_imm;
        end
      end
      i_inst_bxx: begin
        o_prdt_taken = (MODE != 0) ? bht[rd_idx][CNT_W-1]
                                   : i_imm[XLEN-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bpu_dyn_bp.sv
// Scoreboard bench: a reference model predicts each cycle,
// a negedge checker compares both MODE instances.
module tb_bpu_dyn_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [31:0] pc;
  logic        jal, jalr, bxx, rs1ren;
  logic [4:0]  rs1_idx, rd_idx;
  logic [31:0] imm, rs1d;
  logic        upd_valid, upd_taken, flush;
  logic [31:0] upd_pc;

  logic        d_taken, s_taken;
  logic [31:0] d_pc, s_pc;
  logic        d_hit, s_hit;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] pc;
    logic        hit;
    logic        st_taken;
  } exp_t;

  exp_t sb[$];

  int          cnt_m [64];
  logic [31:0] ras_m [4];
  int          sp_m;
  int          n_m;

  always #5 clk = ~clk;

  bpu_dyn_bp #(.MODE(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid),
    .i_pc(pc), .i_inst_jal(jal), .i_inst_jalr(jalr),
    .i_inst_bxx(bxx), .i_inst_rs1ren(rs1ren),
    .i_rs1_idx(rs1_idx), .i_rd_idx(rd_idx), .i_imm(imm),
    .i_jalr_rs1rdata(rs1d), .i_upd_valid(upd_valid),
    .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
    .i_ras_flush(flush), .o_prdt_taken(d_taken),
    .o_prdt_pc(d_pc), .o_ras_hit(d_hit)
  );

  bpu_dyn_bp #(.MODE(0)) u_st (
    .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid),
    .i_pc(pc), .i_inst_jal(jal), .i_inst_jalr(jalr),
    .i_inst_bxx(bxx), .i_inst_rs1ren(rs1ren),
    .i_rs1_idx(rs1_idx), .i_rd_idx(rd_idx), .i_imm(imm),
    .i_jalr_rs1rdata(rs1d), .i_upd_valid(upd_valid),
    .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
    .i_ras_flush(flush), .o_prdt_taken(s_taken),
    .o_prdt_pc(s_pc), .o_ras_hit(s_hit)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".taken"}, 32'(d_taken), 32'(e.taken));
      check({e.tag, ".pc"}, d_pc, e.pc);
      check({e.tag, ".hit"}, 32'(d_hit), 32'(e.hit));
      check({e.tag, ".st_taken"}, 32'(s_taken), 32'(e.st_taken));
    end
  end

  function automatic logic lnk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt_m[i] = 1;
    sp_m = 0;
    n_m  = 0;
  endtask

  task automatic idle();
    dec_valid = 1'b0; pc = '0; jal = 1'b0; jalr = 1'b0;
    bxx = 1'b0; rs1ren = 1'b0; rs1_idx = '0; rd_idx = '0;
    imm = '0; rs1d = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic step(
    input string tag, input logic v, input logic [31:0] p,
    input logic j, input logic jr, input logic b,
    input logic ren, input logic [4:0] rs1, input logic [4:0] rd,
    input logic [31:0] im, input logic [31:0] r1d,
    input logic uv, input logic [31:0] upc, input logic ut,
    input logic fl);
    exp_t e;
    logic ps, pp;
    int   idx, uidx;
    dec_valid = v; pc = p; jal = j; jalr = jr; bxx = b;
    rs1ren = ren; rs1_idx = rs1; rd_idx = rd; imm = im;
    rs1d = r1d; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    flush = fl;
    ps  = (j | jr) & lnk(rd);
    pp  = jr & lnk(rs1) & ~(lnk(rd) & (rd == rs1));
    idx = int'(p[7:2]);
    e.tag = tag; e.taken = 1'b0; e.pc = p + im; e.hit = 1'b0;
    if (j) begin
      e.taken = 1'b1;
    end else if (jr) begin
      e.taken = 1'b1;
      if (pp && n_m > 0) begin
        e.pc  = ras_m[(sp_m + 3) % 4];
        e.hit = 1'b1;
      end else begin
        e.pc = ren ? r1d + im : im;
      end
    end else if (b) begin
      e.taken = (cnt_m[idx] >= 2);
    end
    e.st_taken = b ? im[31] : e.taken;
    sb.push_back(e);
    @(posedge clk);
    if (uv) begin
      uidx = int'(upc[7:2]);
      if (ut && cnt_m[uidx] < 3) cnt_m[uidx]++;
      if (!ut && cnt_m[uidx] > 0) cnt_m[uidx]--;
    end
    if (fl) begin
      sp_m = 0;
      n_m  = 0;
    end else if (v) begin
      if (ps && (!pp || n_m == 0)) begin
        ras_m[sp_m] = p + 32'd4;
        sp_m = (sp_m + 1) % 4;
        if (n_m < 4) n_m++;
      end else if (ps && pp) begin
        ras_m[(sp_m + 3) % 4] = p + 32'd4;
      end else if (pp && n_m > 0) begin
        sp_m = (sp_m + 3) % 4;
        n_m--;
      end
    end
    #1;
  endtask

  task automatic upd(input string tag, input logic t);
    step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, t, 0);
  endtask

  task automatic br(input string tag, input logic [31:0] p,
                    input logic [31:0] im);
    step(tag, 1, p, 0, 0, 1, 0, 0, 0, im, 0, 0, 0, 0, 0);
  endtask

  task automatic call(input string tag, input logic [31:0] p,
                      input logic [4:0] rd, input logic fl);
    step(tag, 1, p, 1, 0, 0, 0, 0, rd, 32'h40, 0, 0, 0, 0, fl);
  endtask

  task automatic ret(input string tag, input logic [4:0] rs1,
                     input logic [4:0] rd);
    step(tag, 1, 32'h600, 0, 1, 0, 1, rs1, rd, 32'h4,
         32'h1000, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input logic uv, input logic ut);
    idle();
    rst = 1'b1;
    upd_valid = uv; upd_pc = 32'h100; upd_taken = ut;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    do_reset(0, 0);
    step("rst_out", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    br("t1_bxx", 32'h100, 32'hFFFF_FFF8);
    br("t1_fwd", 32'h100, 32'h0000_0010);

    upd("t2_u1", 1);
    upd("t2_u2", 1);
    br("t2_t", 32'h100, 32'hFFFF_FFF8);
    upd("t2_u3", 1);
    upd("t2_u4", 1);
    step("t2_rdold", 1, 32'h100, 0, 0, 1, 0, 0, 0, 32'h8,
         0, 1, 32'h100, 0, 0);
    br("t2_nt1", 32'h100, 32'h8);
    upd("t2_u6", 0);
    br("t2_nt2", 32'h100, 32'h8);
    br("t2_other", 32'h104, 32'h8);

    call("t3_jal", 32'h200, 5'd1, 0);
    ret("t3_ret", 5'd1, 5'd0);
    ret("t3_ret2", 5'd1, 5'd0);
    step("t3_imm", 1, 32'h700, 0, 1, 0, 0, 5'd2, 5'd0,
         32'h123, 32'h5555, 0, 0, 0, 0);
    step("t3_wrap", 1, 32'hFFFF_FFF0, 1, 0, 0, 0, 0, 0,
         32'h20, 0, 0, 0, 0, 0);

    for (int k = 1; k <= 5; k++) begin
      call($sformatf("t4_push%0d", k), 32'(k * 16), 5'd1, 0);
    end
    for (int k = 1; k <= 5; k++) begin
      ret($sformatf("t4_pop%0d", k), 5'd1, 5'd0);
    end

    call("t5_jal", 32'h300, 5'd5, 0);
    step("t5_swap", 1, 32'h400, 0, 1, 0, 1, 5'd5, 5'd1,
         32'h0, 32'h2000, 0, 0, 0, 0);
    ret("t5_ret", 5'd1, 5'd0);
    ret("t5_ret_e", 5'd5, 5'd0);
    step("t5_nv", 0, 32'h500, 1, 0, 0, 0, 0, 5'd1,
         32'h8, 0, 0, 0, 0, 0);
    ret("t5_ret_nv", 5'd1, 5'd0);
    call("t5_same", 32'h540, 5'd1, 0);
    ret("t5_rr", 5'd1, 5'd1);
    ret("t5_after", 5'd1, 5'd0);

    call("t6_jal", 32'h800, 5'd1, 0);
    call("t6_fl", 32'h900, 5'd1, 1);
    ret("t6_ret", 5'd1, 5'd0);
    upd("t6_u1", 1);
    upd("t6_u2", 1);
    do_reset(1, 1);
    br("t6_rstbht", 32'h100, 32'h8);
    upd("t6_u3", 1);
    br("t6_rstbht2", 32'h100, 32'h8);

    idle();
    @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
